// File: rtl/pc_rx_pkg.sv
// pc_rx_pkg: shared types and constants for the PCIe P2L receive dispatcher.
//   - state_e   : dispatcher FSM states
//   - hdr_t     : header fields found in bits [127:88] of a header word
//   - bit positions of the header fields, data/length widths, magic default
//   - hdr_len_ok: legal-length check for a header
package pc_rx_pkg;

  localparam int DATA_W  = 128;
  localparam int LEN_W   = 16;
  localparam int CNT_W   = 16;
  localparam int CH_ID_W = 8;
  // Channel select register width; covers up to 8 channels.
  localparam int SEL_W   = 3;

  localparam logic [15:0] HDR_MAGIC_DEFAULT = 16'h55AA;

  localparam int HDR_MAGIC_MSB = 127;
  localparam int HDR_MAGIC_LSB = 112;
  localparam int HDR_CHID_MSB  = 111;
  localparam int HDR_CHID_LSB  = 104;
  localparam int HDR_LEN_MSB   = 103;
  localparam int HDR_LEN_LSB   = 88;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DRAIN   = 2'd2
  } state_e;

  // Field order matches the header word from bit 127 down to bit 88.
  typedef struct packed {
    logic [15:0]         magic;
    logic [CH_ID_W-1:0]  ch_id;
    logic [LEN_W-1:0]    len;
  } hdr_t;

  // A length is legal when it is non-zero and no larger than max_len.
  function automatic logic hdr_len_ok(input logic [LEN_W-1:0] len,
                                      input logic [LEN_W-1:0] max_len);
    return (len != '0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/pc_rx_cmd_dispatch_sat_cnt16.sv
// sat_cnt16: 16-bit saturating event counter with synchronous clear.
//   clk   : clock
//   rst_n : asynchronous active-low reset, clears the count
//   clr   : synchronous clear, wins over a simultaneous increment
//   inc   : count one event; the count sticks at 16'hFFFF
//   cnt   : current count
module sat_cnt16
  import pc_rx_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pc_rx_cmd_dispatch.sv
// pc_rx_cmd_dispatch: drains the 128-bit P2L FIFO (first-word-fall-through),
// parses a one-word header and forwards the payload words to one of NUM_CH
// valid/ready consumers, keeping packet, header-error and drop counters.
//   pcie_clk_250m     : sole clock
//   rst               : asynchronous active-low reset
//   fifo_data_P2L_en  : FIFO pop strobe
//   fifo_data_P2L     : FIFO head word
//   fifo_data_P2L_emp : FIFO empty
//   ch_data           : payload word shared by all channels
//   ch_valid/ch_ready : per-channel handshake, valid is one-hot
//   ch_sop/ch_eop     : first/last payload word of a packet
//   ch_len            : length of the current packet
//   err_clr           : synchronous clear of hdr_err_cnt and drop_cnt
//   busy              : packet in progress (payload or drain)
//   pkt_cnt           : packets fully delivered (wraps)
//   hdr_err_cnt       : rejected headers (saturating)
//   drop_cnt          : packets addressed to a missing channel (saturating)
module pc_rx_cmd_dispatch
  import pc_rx_pkg::*;
#(
  parameter int               NUM_CH    = 4,
  parameter logic [LEN_W-1:0] MAX_LEN   = 16'd1024,
  parameter logic [15:0]      HDR_MAGIC = HDR_MAGIC_DEFAULT
)(
  input  logic              pcie_clk_250m,
  input  logic              rst,
  output logic              fifo_data_P2L_en,
  input  logic [DATA_W-1:0] fifo_data_P2L,
  input  logic              fifo_data_P2L_emp,
  output logic [DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0] ch_valid,
  input  logic [NUM_CH-1:0] ch_ready,
  output logic              ch_sop,
  output logic              ch_eop,
  output logic [LEN_W-1:0]  ch_len,
  input  logic              err_clr,
  output logic              busy,
  output logic [31:0]       pkt_cnt,
  output logic [CNT_W-1:0]  hdr_err_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  state_e           state_q, state_d;
  logic [LEN_W-1:0] remain_q, remain_d;
  logic [LEN_W-1:0] ch_len_q, ch_len_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [31:0]      pkt_cnt_q, pkt_cnt_d;
  // Two-stage release of the reset: popping only starts once the
  // deassertion has been synchronised, so the FIFO is never popped while
  // rst is low or on the edge where it is released.
  logic [1:0]       run_q, run_d;

  hdr_t             hdr;
  logic             hdr_ok;
  logic             ch_in_range;
  logic             ready_sel;
  logic             valid;
  logic             pop;
  logic             hdr_err_inc;
  logic             drop_inc;

  assign hdr         = hdr_t'(fifo_data_P2L[HDR_MAGIC_MSB:HDR_LEN_LSB]);
  assign hdr_ok      = (hdr.magic == HDR_MAGIC) && hdr_len_ok(hdr.len, MAX_LEN);
  assign ch_in_range = int'(hdr.ch_id) < NUM_CH;

  // Ready of the currently selected channel.
  always_comb begin
    ready_sel = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel_q == SEL_W'(i)) begin
        ready_sel = ch_ready[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    ch_len_d    = ch_len_q;
    sel_d       = sel_q;
    pkt_cnt_d   = pkt_cnt_q;
    run_d       = {run_q[0], 1'b1};
    valid       = 1'b0;
    pop         = 1'b0;
    hdr_err_inc = 1'b0;
    drop_inc    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pop = run_q[1] & ~fifo_data_P2L_emp;
        if (pop) begin
          // A rejected word is simply consumed, so the parser slides
          // forward one word at a time until a good header appears.
          if (!hdr_ok) begin
            hdr_err_inc = 1'b1;
          end else if (ch_in_range) begin
            sel_d    = hdr.ch_id[SEL_W-1:0];
            ch_len_d = hdr.len;
            remain_d = hdr.len;
            state_d  = ST_PAYLOAD;
          end else begin
            remain_d = hdr.len;
            state_d  = ST_DRAIN;
          end
        end
      end

      ST_PAYLOAD: begin
        valid = ~fifo_data_P2L_emp;
        pop   = valid & ready_sel;
        if (pop) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == 16'd1) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            state_d   = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        pop = ~fifo_data_P2L_emp;
        if (pop) begin
          remain_d = remain_q - 1'b1;
          if (remain_q == 16'd1) begin
            drop_inc = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge pcie_clk_250m or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      remain_q  <= '0;
      ch_len_q  <= '0;
      sel_q     <= '0;
      pkt_cnt_q <= '0;
      run_q     <= '0;
    end else begin
      state_q   <= state_d;
      remain_q  <= remain_d;
      ch_len_q  <= ch_len_d;
      sel_q     <= sel_d;
      pkt_cnt_q <= pkt_cnt_d;
      run_q     <= run_d;
    end
  end

  // The valid strobe is steered only onto the latched channel.
  always_comb begin
    ch_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_valid[i] = valid && (sel_q == SEL_W'(i));
    end
  end

  sat_cnt16 u_hdr_err_cnt (
    .clk   (pcie_clk_250m),
    .rst_n (rst),
    .clr   (err_clr),
    .inc   (hdr_err_inc),
    .cnt   (hdr_err_cnt)
  );

  sat_cnt16 u_drop_cnt (
    .clk   (pcie_clk_250m),
    .rst_n (rst),
    .clr   (err_clr),
    .inc   (drop_inc),
    .cnt   (drop_cnt)
  );

  // Payload passes straight through from the FIFO head; it stays put while
  // stalled because nothing is popped until the consumer is ready.
  assign ch_data          = fifo_data_P2L;
  assign ch_sop           = valid & (remain_q == ch_len_q);
  assign ch_eop           = valid & (remain_q == 16'd1);
  assign ch_len           = ch_len_q;
  assign fifo_data_P2L_en = pop;
  assign busy             = (state_q != ST_IDLE);
  assign pkt_cnt          = pkt_cnt_q;

endmodule

// File: tb/tb_pc_rx_cmd_dispatch.sv
// tb_pc_rx_cmd_dispatch: self-checking bench for pc_rx_cmd_dispatch.
// A queue models the FWFT FIFO; a stream-level parser predicts the delivered
// beats and the counters; a negedge monitor compares every handshake.
module tb_pc_rx_cmd_dispatch;

  localparam int          NUM_CH  = 4;
  localparam int          MAX_LEN = 1024;
  localparam logic [15:0] MAGIC   = 16'h55AA;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               fifo_en;
  logic [127:0]       fifo_head;
  logic               fifo_emp;
  logic [127:0]       ch_data;
  logic [NUM_CH-1:0]  ch_valid;
  logic [NUM_CH-1:0]  ch_ready;
  logic               ch_sop;
  logic               ch_eop;
  logic [15:0]        ch_len;
  logic               err_clr;
  logic               busy;
  logic [31:0]        pkt_cnt;
  logic [15:0]        hdr_err_cnt;
  logic [15:0]        drop_cnt;

  always #2 clk = ~clk;

  pc_rx_cmd_dispatch #(
    .NUM_CH    (NUM_CH),
    .MAX_LEN   (16'd1024),
    .HDR_MAGIC (16'h55AA)
  ) dut (
    .pcie_clk_250m     (clk),
    .rst               (rst_n),
    .fifo_data_P2L_en  (fifo_en),
    .fifo_data_P2L     (fifo_head),
    .fifo_data_P2L_emp (fifo_emp),
    .ch_data           (ch_data),
    .ch_valid          (ch_valid),
    .ch_ready          (ch_ready),
    .ch_sop            (ch_sop),
    .ch_eop            (ch_eop),
    .ch_len            (ch_len),
    .err_clr           (err_clr),
    .busy              (busy),
    .pkt_cnt           (pkt_cnt),
    .hdr_err_cnt       (hdr_err_cnt),
    .drop_cnt          (drop_cnt)
  );

  typedef struct packed {
    logic [2:0]   ch;
    logic         sop;
    logic         eop;
    logic [15:0]  len;
    logic [127:0] data;
  } beat_t;

  typedef struct {
    logic [15:0] magic;
    logic [7:0]  ch;
    logic [15:0] len;
    int          n_pay;
    int          d_err;
    int          d_drop;
    int          d_pkt;
    int          pops;
  } vec_t;

  beat_t        exp_q[$];
  logic [127:0] fifo_q[$];
  int           check_count = 0;
  int           error_count = 0;
  int           pop_count   = 0;
  int           exp_pkt = 0, exp_err = 0, exp_drop = 0;
  logic         hold_empty  = 1'b0;
  logic         prev_stall  = 1'b0;
  logic [127:0] prev_data;
  logic [3:0]   prev_valid;
  logic         saw_valid   = 1'b0;

  task automatic checkOutput(input string name, input logic [255:0] got,
                             input logic [255:0] want);
    check_count++;
    if (got !== want) begin
      error_count++;
      $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic refresh_fifo();
    fifo_emp  = hold_empty || (fifo_q.size() == 0);
    fifo_head = (fifo_q.size() != 0) ? fifo_q[0] : '0;
  endtask

  function automatic logic [127:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [127:0] mk_hdr(input logic [15:0] magic,
                                          input logic [7:0] ch,
                                          input logic [15:0] len);
    logic [127:0] w;
    w = rand_word();
    w[127:88] = {magic, ch, len};
    return w;
  endfunction

  // Reference parser: walks the word stream with the header rules and lists
  // the beats each consumer should see plus the counter effects.
  task automatic model_stream(input logic [127:0] words[$]);
    int i = 0;
    while (i < words.size()) begin
      logic [15:0] magic;
      logic [7:0]  ch;
      logic [15:0] len;
      logic [127:0] w;
      w     = words[i];
      magic = w[127:112];
      ch    = w[111:104];
      len   = w[103:88];
      if (magic != MAGIC || len == 0 || int'(len) > MAX_LEN) begin
        if (exp_err < 65535) exp_err++;
        i++;
      end else if (int'(ch) < NUM_CH) begin
        for (int k = 1; k <= int'(len); k++) begin
          beat_t b;
          b.ch   = ch[2:0];
          b.sop  = (k == 1);
          b.eop  = (k == int'(len));
          b.len  = len;
          b.data = words[i + k];
          exp_q.push_back(b);
        end
        exp_pkt++;
        i += int'(len) + 1;
      end else begin
        if (exp_drop < 65535) exp_drop++;
        i += int'(len) + 1;
      end
    end
  endtask

  task automatic make_pkt(input logic [15:0] magic, input logic [7:0] ch,
                          input logic [15:0] len, input int n_pay,
                          output logic [127:0] words[$]);
    words.delete();
    words.push_back(mk_hdr(magic, ch, len));
    for (int k = 0; k < n_pay; k++) words.push_back(rand_word());
  endtask

  task automatic push_stream(input logic [127:0] words[$]);
    foreach (words[k]) fifo_q.push_back(words[k]);
    model_stream(words);
    refresh_fifo();
  endtask

  task automatic monitor();
    beat_t got;
    beat_t want;
    logic  hs;
    if (fifo_emp) checkOutput("idle_when_empty", {fifo_en, ch_valid}, '0);
    if (ch_valid != '0) begin
      saw_valid = 1'b1;
      checkOutput("valid_onehot", ((ch_valid & (ch_valid - 4'd1)) == 4'd0), 1);
      if (prev_stall) checkOutput("stall_hold", {ch_valid, ch_data}, {prev_valid, prev_data});
      hs = |(ch_valid & ch_ready);
      checkOutput("pop_on_handshake", fifo_en, hs);
      if (hs) begin
        got.ch = '0;
        for (int i = 0; i < NUM_CH; i++) if (ch_valid[i]) got.ch = 3'(i);
        got.sop  = ch_sop;
        got.eop  = ch_eop;
        got.len  = ch_len;
        got.data = ch_data;
        checkOutput("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          want = exp_q.pop_front();
          checkOutput("beat", got, want);
        end
      end
      prev_stall = !hs;
      prev_valid = ch_valid;
      prev_data  = ch_data;
    end else begin
      prev_stall = 1'b0;
      checkOutput("sop_eop_idle", {ch_sop, ch_eop}, '0);
    end
  endtask

  task automatic tick();
    logic pop;
    @(negedge clk);
    monitor();
    pop = fifo_en;
    @(posedge clk);
    #1;
    if (pop) begin
      pop_count++;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
    end
    refresh_fifo();
  endtask

  task automatic run_until_idle(input int budget, input bit rnd);
    int n = 0;
    while ((fifo_q.size() != 0 || busy || exp_q.size() != 0) && n < budget) begin
      if (rnd) begin
        ch_ready   = NUM_CH'($urandom);
        hold_empty = ($urandom_range(0, 4) == 0);
        refresh_fifo();
      end
      tick();
      n++;
    end
    hold_empty = 1'b0;
    refresh_fifo();
    checkOutput("drain_in_budget", n < budget, 1);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [127:0] words[$];
    make_pkt(v.magic, v.ch, v.len, v.n_pay, words);
    ch_ready = '1;
    push_stream(words);
  endtask

  task automatic check_counters(input string tag);
    checkOutput({tag, "_pkt_cnt"}, pkt_cnt, exp_pkt);
    checkOutput({tag, "_hdr_err_cnt"}, hdr_err_cnt, exp_err);
    checkOutput({tag, "_drop_cnt"}, drop_cnt, exp_drop);
  endtask

  vec_t vecs[9];

  initial begin
    logic [127:0] words[$];
    int           pat[5];
    int           base_err, base_drop, base_pkt, base_pops;

    vecs[0] = '{16'h55AA, 8'd1, 16'd3,    3,    0, 0, 1, 4};
    vecs[1] = '{16'h1234, 8'd0, 16'd1,    0,    1, 0, 0, 1};
    vecs[2] = '{16'h55AA, 8'd0, 16'd1,    1,    0, 0, 1, 2};
    vecs[3] = '{16'h55AA, 8'd7, 16'd2,    2,    0, 1, 0, 3};
    vecs[4] = '{16'h55AA, 8'd2, 16'd0,    0,    1, 0, 0, 1};
    vecs[5] = '{16'h55AA, 8'd3, 16'd1025, 0,    1, 0, 0, 1};
    vecs[6] = '{16'h55AA, 8'd3, 16'd1024, 1024, 0, 0, 1, 1025};
    vecs[7] = '{16'h55AA, 8'd4, 16'd1,    1,    0, 1, 0, 2};
    vecs[8] = '{16'h55AA, 8'd3, 16'd1,    1,    0, 0, 1, 2};

    rst_n    = 1'b0;
    err_clr  = 1'b0;
    ch_ready = '0;
    fifo_q.push_back(mk_hdr(MAGIC, 8'd0, 16'd1));
    refresh_fifo();
    repeat (3) tick();
    checkOutput("reset_outputs",
                {fifo_en, ch_valid, ch_sop, ch_eop, busy, pkt_cnt, hdr_err_cnt, drop_cnt, ch_len}, '0);
    fifo_q.delete();
    refresh_fifo();
    rst_n = 1'b1;
    repeat (3) tick();

    for (int v = 0; v < 9; v++) begin
      base_err  = exp_err;
      base_drop = exp_drop;
      base_pkt  = exp_pkt;
      base_pops = pop_count;
      saw_valid = 1'b0;
      applyStimulus(vecs[v]);
      run_until_idle(1200, 1'b0);
      checkOutput($sformatf("vec%0d_hdr_err", v), hdr_err_cnt, base_err + vecs[v].d_err);
      checkOutput($sformatf("vec%0d_drop", v), drop_cnt, base_drop + vecs[v].d_drop);
      checkOutput($sformatf("vec%0d_pkt", v), pkt_cnt, base_pkt + vecs[v].d_pkt);
      checkOutput($sformatf("vec%0d_pops", v), pop_count - base_pops, vecs[v].pops);
      checkOutput($sformatf("vec%0d_valid_seen", v), saw_valid, vecs[v].d_pkt != 0);
      checkOutput($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Consumer backpressure 1-0-0-1-1 on channel 1.
    pat = '{1, 0, 0, 1, 1};
    base_pkt  = exp_pkt;
    base_pops = pop_count;
    make_pkt(MAGIC, 8'd1, 16'd3, 3, words);
    ch_ready = '0;
    push_stream(words);
    tick();
    for (int i = 0; i < 5; i++) begin
      ch_ready = pat[i] ? 4'b0010 : 4'b0000;
      tick();
    end
    checkOutput("bp_pkt", pkt_cnt, base_pkt + 1);
    checkOutput("bp_pops", pop_count - base_pops, 4);
    checkOutput("bp_busy", busy, 0);
    checkOutput("bp_all_delivered", exp_q.size(), 0);
    ch_ready = '1;

    // Error counter clear, then two bad lengths, then clear racing a third.
    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    exp_err  = 0;
    exp_drop = 0;
    check_counters("clr");
    make_pkt(MAGIC, 8'd0, 16'd0, 0, words);
    push_stream(words);
    make_pkt(MAGIC, 8'd1, 16'd1025, 0, words);
    push_stream(words);
    run_until_idle(50, 1'b0);
    checkOutput("two_bad_len", hdr_err_cnt, 2);
    make_pkt(16'hBEEF, 8'd0, 16'd1, 0, words);
    push_stream(words);
    err_clr = 1'b1;
    tick();
    err_clr  = 1'b0;
    exp_err  = 0;
    exp_drop = 0;
    checkOutput("clr_vs_inc_popped", fifo_q.size(), 0);
    checkOutput("clr_vs_inc", hdr_err_cnt, 0);

    // FIFO runs dry mid-packet for 10 cycles.
    base_pkt = exp_pkt;
    make_pkt(MAGIC, 8'd2, 16'd4, 4, words);
    model_stream(words);
    for (int k = 0; k < 3; k++) fifo_q.push_back(words[k]);
    refresh_fifo();
    repeat (3) tick();
    repeat (10) tick();
    checkOutput("gap_state", {busy, ch_valid, ch_len}, {1'b1, 4'b0000, 16'd4});
    fifo_q.push_back(words[3]);
    fifo_q.push_back(words[4]);
    refresh_fifo();
    run_until_idle(50, 1'b0);
    checkOutput("gap_pkt", pkt_cnt, base_pkt + 1);

    // Asynchronous reset in the middle of a payload.
    make_pkt(MAGIC, 8'd0, 16'd5, 5, words);
    push_stream(words);
    repeat (3) tick();
    checkOutput("pre_reset_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset",
                {fifo_en, ch_valid, ch_sop, ch_eop, busy, pkt_cnt, hdr_err_cnt, drop_cnt, ch_len}, '0);
    fifo_q.delete();
    exp_q.delete();
    exp_pkt    = 0;
    exp_err    = 0;
    exp_drop   = 0;
    prev_stall = 1'b0;
    refresh_fifo();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Randomised packet mix with random backpressure and FIFO gaps.
    words.delete();
    for (int p = 0; p < 40; p++) begin
      int           r;
      logic [15:0]  m;
      logic [15:0]  l;
      logic [127:0] pw[$];
      r = $urandom_range(0, 19);
      if (r < 12) begin
        l = 16'($urandom_range(1, 8));
        make_pkt(MAGIC, 8'($urandom_range(0, NUM_CH - 1)), l, int'(l), pw);
      end else if (r < 15) begin
        l = 16'($urandom_range(1, 4));
        make_pkt(MAGIC, 8'($urandom_range(NUM_CH, 255)), l, int'(l), pw);
      end else if (r < 18) begin
        m = 16'($urandom);
        if (m == MAGIC) m = 16'h1234;
        make_pkt(m, 8'($urandom_range(0, 3)), 16'd1, 0, pw);
      end else begin
        l = (r == 18) ? 16'd0 : 16'($urandom_range(MAX_LEN + 1, 65535));
        make_pkt(MAGIC, 8'($urandom_range(0, 3)), l, 0, pw);
      end
      foreach (pw[k]) words.push_back(pw[k]);
    end
    push_stream(words);
    run_until_idle(6000, 1'b1);
    check_counters("random");
    checkOutput("random_all_delivered", exp_q.size(), 0);
    checkOutput("random_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/pc_rx_cmd_dispatch.md
Name: pc_rx_cmd_dispatch

Overview:
- Drains the 128-bit P2L FIFO, which carries PC-to-logic words received over PCIe.
- Parses a one-word packet header and routes the following payload words to one of NUM_CH downstream consumers using valid/ready handshakes.
- Replaces unconditional FIFO draining with flow-controlled, per-channel dispatch, and keeps error and statistics counters.
- Sits between the PCIe RX FIFO and the per-function command/data sinks in the pcie_clk_250m domain.

Parameters:
- NUM_CH, 4, number of downstream channels (1..8).
- MAX_LEN, 16'd1024, maximum legal payload length in 128-bit words.
- HDR_MAGIC, 16'h55AA, required value of header bits [127:112].

Ports:
- pcie_clk_250m  in  1  sole clock.
- rst  in  1  asynchronous active-low reset.
- fifo_data_P2L_en  out  1  FIFO pop strobe.
- fifo_data_P2L  in  128  FIFO head word, first-word-fall-through (valid whenever not empty).
- fifo_data_P2L_emp  in  1  FIFO empty.
- ch_data  out  128  payload word, shared by all channels.
- ch_valid  out  NUM_CH  one-hot valid for the selected channel.
- ch_ready  in  NUM_CH  per-channel ready.
- ch_sop  out  1  first payload word of a packet.
- ch_eop  out  1  last payload word of a packet.
- ch_len  out  16  length of the current packet, held for the whole packet.
- err_clr  in  1  synchronous clear of the error counters.
- busy  out  1  high when state is not IDLE.
- pkt_cnt  out  32  packets fully delivered.
- hdr_err_cnt  out  16  headers rejected (bad magic or bad length), saturating.
- drop_cnt  out  16  packets discarded because channel id >= NUM_CH, saturating.

Behaviour:
- Header format:
  - [127:112] magic.
  - [111:104] channel id.
  - [103:88] length LEN in words.
  - [87:0] ignored.
- Reset (rst=0, asynchronous):
  - State is IDLE.
  - All counters, ch_len and the selected-channel register are 0.
  - fifo_data_P2L_en, ch_valid, ch_sop, ch_eop and busy are 0.
  - fifo_data_P2L_en is gated by the reset-synchronised state, so it is never high during reset.
- IDLE:
  - fifo_data_P2L_en = ~emp, so a header is consumed in one cycle.
  - On a popped word: magic and LEN checks are evaluated first.
  - Magic != HDR_MAGIC, or LEN == 0, or LEN > MAX_LEN: increment hdr_err_cnt, stay in IDLE. This gives word-by-word resynchronisation.
  - Otherwise, channel id < NUM_CH: latch the channel and LEN, load remain = LEN, go to PAYLOAD.
  - Otherwise (channel id >= NUM_CH): load remain = LEN, go to DRAIN.
- PAYLOAD (zero-latency pass-through):
  - ch_valid[sel] = ~emp; ch_data = fifo_data_P2L.
  - fifo_data_P2L_en = ~emp & ch_ready[sel].
  - ch_sop = valid & (remain == ch_len).
  - ch_eop = valid & (remain == 1).
  - Each accepted word decrements remain.
  - The beat with eop accepted: increment pkt_cnt (wraps), go to IDLE.
  - Data on ch_data is held stable while valid is high and ready is low.
  - ch_valid is never asserted on a non-selected channel.
- DRAIN:
  - fifo_data_P2L_en = ~emp; ch_valid = 0.
  - Decrement remain per popped word.
  - On the last word: increment drop_cnt, go to IDLE.
- FIFO empty mid-packet: stall with no timeout; valid deasserts and resumes when data returns.
- The next header can be popped in the cycle after eop; there are no idle bubbles other than the header cycle.
- Counters:
  - hdr_err_cnt and drop_cnt saturate at 16'hFFFF.
  - err_clr clears both and takes priority over a simultaneous increment.
- busy = (state != IDLE).
- Reset mid-packet aborts the packet; the remaining payload words are treated as headers after reset. This is accepted behaviour, and host software resets the FIFO with the logic.

Decomposition:
- Package pc_rx_pkg holds:
  - State enum (IDLE, PAYLOAD, DRAIN).
  - Header field bit positions.
  - HDR_MAGIC default.
  - Width constants (DATA_W = 128, LEN_W = 16).
- Single module. The saturating counter may be a small sub-module sat_cnt16, instantiated twice.

Test Plan:
- Header {55AA, ch1, LEN=3} plus 3 words, ch_ready=all 1:
  - ch_valid = 4'b0010 for 3 consecutive cycles.
  - sop on word 1, eop on word 3.
  - pkt_cnt = 1; total pops = 4.
- Same packet with ch_ready[1] toggling 1-0-0-1-1:
  - No word is lost or duplicated.
  - ch_data is stable while stalled.
  - fifo_data_P2L_en is high only on handshake cycles.
- Header magic 16'h1234, then a valid header {55AA, ch0, LEN=1} plus 1 word:
  - hdr_err_cnt = 1.
  - The packet is delivered on ch0; pkt_cnt = 1.
- Header {55AA, ch7, LEN=2} with NUM_CH=4:
  - 3 pops, no ch_valid.
  - drop_cnt = 1; busy = 0 afterwards.
- Header LEN=0 and a header with LEN=1025:
  - hdr_err_cnt = 2.
  - Assert err_clr in the same cycle as a third bad header: counter reads 0.
- FIFO empty for 10 cycles mid-packet, then rst pulsed low during PAYLOAD:
  - Valid drops during the gap and the packet completes correctly.
  - On reset, all outputs and counters return to 0 immediately (asynchronously) and state is IDLE.
